ad1_reader: RTL and testbench
=============================

AD1_READER -- requirements
Module: ad1_reader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 3, meaning clk_in cycles per SCLK half-period (legal range 1..255).
REQ-002 SHALL have parameter QUIET_CYC, default 5, meaning clk_in cycles that ncs is held high after a frame before the next start is accepted (legal range 1..255).
REQ-003 SHALL have port clk_in, input, width 1, the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, width 1, the reset; one clock, reset synchronous and active-high.
REQ-005 SHALL have port start, input, width 1, a conversion request, sampled only in IDLE.
REQ-006 SHALL have port sdata1, input, width 1, serial data from ADC channel 1.
REQ-007 SHALL have port sdata2, input, width 1, serial data from ADC channel 2.
REQ-008 SHALL have port ncs, output, width 1, the active-low chip select to both ADCs.
REQ-009 SHALL have port sclk, output, width 1, the serial clock to both ADCs, idling high.
REQ-010 SHALL have port data1, output, width 12, the last completed channel-1 sample.
REQ-011 SHALL have port data2, output, width 12, the last completed channel-2 sample.
REQ-012 SHALL have port done, output, width 1, a one-cycle pulse when data1/data2 update.
REQ-013 SHALL have port busy, output, width 1, high from ncs falling until QUIET ends.
REQ-014 SHALL have port frame_err, output, width 1, the leading-zero violation flag for the last frame.

Function
REQ-015 SHALL implement states IDLE, SHIFT and QUIET, with IDLE entered at reset.
REQ-016 SHALL, in IDLE with start=1 at cycle N, drive ncs=0, busy=1, enter SHIFT at cycle N+1 and clear the divider and edge counters.
REQ-017 SHALL, in SHIFT, toggle sclk every CLK_DIV cycles, with the first toggle (high to low) at cycle N+1+CLK_DIV, for exactly 32 toggles (16 SCLK periods).
REQ-018 SHALL, on each low-to-high sclk toggle, shift the sdata1/sdata2 values present in that same cycle into two 16-bit shift registers, MSB first.
REQ-019 SHALL, at cycle N+1+32*CLK_DIV (the 16th rising toggle), set ncs=1, load data1/data2 from shift register bits [11:0], pulse done for one cycle, and enter QUIET.
REQ-020 SHALL hold ncs=1 and busy=1 in QUIET for QUIET_CYC cycles, then return to IDLE with busy=0; a start present on the IDLE-entry cycle SHALL be accepted.
REQ-021 SHALL ignore start while busy=1, without queuing it.
REQ-022 SHALL hold data1/data2 stable between done pulses.
REQ-023 SHALL never drive sclk low while ncs=1.

Reset
REQ-024 SHALL, on rst=1 at any clock edge including mid-frame, apply ncs=1, sclk=1, done=0, busy=0, frame_err=0, data1=0, data2=0, clear the counters and shift registers, enter IDLE, and produce no done pulse for the aborted frame.
REQ-025 SHALL give rst priority over start when both are asserted in the same cycle.

Configuration
REQ-026 SHALL, with macro AD1_ZERO_CHECK_EN defined, set frame_err together with done to 1 when any of shift bits [15:12] on either channel is 1, and otherwise to 0; data is loaded regardless of the flag.
REQ-027 SHALL, without AD1_ZERO_CHECK_EN, tie frame_err constantly to 0.

Verification
REQ-028 Basic frame (CLK_DIV=3, start pulsed at cycle 0, ADC model driving ch1=0x0A5C and ch2=0x0FFF) -> ncs low at cycle 1, 32 sclk toggles, done at cycle 97, data1=0xA5C, data2=0xFFF, frame_err=0.
REQ-029 Start held high continuously (QUIET_CYC=5) -> second ncs fall at cycle 103, done pulses 102 cycles apart, no start accepted while busy.
REQ-030 rst asserted at cycle 40 mid-frame -> at cycle 41 ncs=1, sclk=1, busy=0, data1=data2=0, and no done pulse occurs.
REQ-031 Channel-1 frame 0x8123 with AD1_ZERO_CHECK_EN defined -> data1=0x123 and frame_err=1 at done; the same frame without the macro gives frame_err=0.
REQ-032 CLK_DIV=1 with alternating frames 0x0000/0x0FFF -> sclk toggles every cycle, done at cycle 33 after start, and data follows each frame exactly.

Source files
------------

// File: rtl/ad1_reader.sv
// Dual-channel serial ADC reader: frames 16 SCLK periods and captures 12-bit samples on both channels.
// Optional leading-zero frame check is enabled by defining AD1_ZERO_CHECK_EN.
module ad1_reader #(
    parameter int unsigned CLK_DIV   = 3,
    parameter int unsigned QUIET_CYC = 5
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        start,
    input  logic        sdata1,
    input  logic        sdata2,
    output logic        ncs,
    output logic        sclk,
    output logic [11:0] data1,
    output logic [11:0] data2,
    output logic        done,
    output logic        busy,
    output logic        frame_err
);

    // Leading bits [15:12] are only observable through the zero check.
`ifdef AD1_ZERO_CHECK_EN
    localparam int unsigned SHIFT_W = 16;
`else
    localparam int unsigned SHIFT_W = 12;
`endif

    localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [7:0] QUIET_LAST = 8'(QUIET_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        QUIET
    } state_t;

    state_t               state, state_next;
    logic [7:0]           div_cnt, div_next;
    logic [4:0]           edge_cnt, edge_next;
    logic [7:0]           quiet_cnt, quiet_next;
    logic [SHIFT_W-1:0]   shift1, shift1_next;
    logic [SHIFT_W-1:0]   shift2, shift2_next;
    logic                 ncs_next, sclk_next, done_next, busy_next;
    logic [11:0]          data1_next, data2_next;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state     <= IDLE;
            div_cnt   <= '0;
            edge_cnt  <= '0;
            quiet_cnt <= '0;
            shift1    <= '0;
            shift2    <= '0;
            ncs       <= 1'b1;
            sclk      <= 1'b1;
            done      <= 1'b0;
            busy      <= 1'b0;
            data1     <= '0;
            data2     <= '0;
        end else begin
            state     <= state_next;
            div_cnt   <= div_next;
            edge_cnt  <= edge_next;
            quiet_cnt <= quiet_next;
            shift1    <= shift1_next;
            shift2    <= shift2_next;
            ncs       <= ncs_next;
            sclk      <= sclk_next;
            done      <= done_next;
            busy      <= busy_next;
            data1     <= data1_next;
            data2     <= data2_next;
        end
    end

    always_comb begin
        state_next  = state;
        div_next    = div_cnt;
        edge_next   = edge_cnt;
        quiet_next  = quiet_cnt;
        shift1_next = shift1;
        shift2_next = shift2;
        ncs_next    = ncs;
        sclk_next   = sclk;
        done_next   = 1'b0;
        busy_next   = busy;
        data1_next  = data1;
        data2_next  = data2;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                    ncs_next   = 1'b0;
                    busy_next  = 1'b1;
                    div_next   = '0;
                    edge_next  = '0;
                end
            end

            SHIFT: begin
                if (div_cnt == DIV_LAST) begin
                    div_next  = '0;
                    sclk_next = ~sclk;
                    edge_next = edge_cnt + 5'd1;
                    // Sample on the edge that raises sclk so the last bit lands with done.
                    if (!sclk) begin
                        shift1_next = {shift1[SHIFT_W-2:0], sdata1};
                        shift2_next = {shift2[SHIFT_W-2:0], sdata2};
                    end
                    if (edge_cnt == 5'd31) begin
                        state_next = QUIET;
                        ncs_next   = 1'b1;
                        done_next  = 1'b1;
                        quiet_next = '0;
                        data1_next = shift1_next[11:0];
                        data2_next = shift2_next[11:0];
                    end
                end else begin
                    div_next = div_cnt + 8'd1;
                end
            end

            QUIET: begin
                if (quiet_cnt == QUIET_LAST) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                end else begin
                    quiet_next = quiet_cnt + 8'd1;
                end
            end

            default: state_next = IDLE;
        endcase
    end

`ifdef AD1_ZERO_CHECK_EN
    logic err_q;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (done_next) begin
            err_q <= |{shift1_next[15:12], shift2_next[15:12]};
        end
    end

    assign frame_err = err_q;
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_ad1_reader.sv
// Scoreboard bench for ad1_reader: instance A (CLK_DIV=3) and instance B (CLK_DIV=1) with ADC models.
module tb_ad1_reader;

    logic        clk_in = 1'b0;
    logic        rst    = 1'b1;
    logic        armed  = 1'b0;

    logic        start_a = 1'b0, sd1_a = 1'b0, sd2_a = 1'b0;
    logic        ncs_a, sclk_a, done_a, busy_a, err_a;
    logic [11:0] data1_a, data2_a;

    logic        start_b = 1'b0, sd1_b = 1'b0, sd2_b = 1'b0;
    logic        ncs_b, sclk_b, done_b, busy_b, err_b;
    logic [11:0] data1_b, data2_b;

`ifdef AD1_ZERO_CHECK_EN
    localparam logic ZC = 1'b1;
`else
    localparam logic ZC = 1'b0;
`endif

    ad1_reader #(.CLK_DIV(3), .QUIET_CYC(5)) u_dut_a (
        .clk_in(clk_in), .rst(rst), .start(start_a), .sdata1(sd1_a), .sdata2(sd2_a),
        .ncs(ncs_a), .sclk(sclk_a), .data1(data1_a), .data2(data2_a),
        .done(done_a), .busy(busy_a), .frame_err(err_a)
    );

    ad1_reader #(.CLK_DIV(1), .QUIET_CYC(5)) u_dut_b (
        .clk_in(clk_in), .rst(rst), .start(start_b), .sdata1(sd1_b), .sdata2(sd2_b),
        .ncs(ncs_b), .sclk(sclk_b), .data1(data1_b), .data2(data2_b),
        .done(done_b), .busy(busy_b), .frame_err(err_b)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // ADC models: present the next word bit, MSB first, after each falling sclk.
    logic [15:0] w1_a = '0, w2_a = '0, w1_b = '0, w2_b = '0;
    int idx_a = 15, idx_b = 15;

    always @(negedge ncs_a) idx_a = 15;
    always @(negedge sclk_a) begin
        if (!ncs_a && idx_a >= 0) begin
            sd1_a = w1_a[idx_a];
            sd2_a = w2_a[idx_a];
            idx_a = idx_a - 1;
        end
    end

    always @(negedge ncs_b) idx_b = 15;
    always @(negedge sclk_b) begin
        if (!ncs_b && idx_b >= 0) begin
            sd1_b = w1_b[idx_b];
            sd2_b = w2_b[idx_b];
            idx_b = idx_b - 1;
        end
    end

    typedef struct {
        logic [11:0] d1;
        logic [11:0] d2;
        logic        err;
        int          at;
    } exp_t;

    typedef struct {
        int          at;
        int          sel;
        logic [11:0] val;
        string       name;
    } probe_t;

    exp_t   q_a[$];
    exp_t   q_b[$];
    probe_t pq[$];

    function automatic logic [11:0] sig(input int sel);
        case (sel)
            0:  return 12'(ncs_a);
            1:  return 12'(sclk_a);
            2:  return 12'(busy_a);
            3:  return 12'(done_a);
            4:  return data1_a;
            5:  return data2_a;
            6:  return 12'(err_a);
            7:  return 12'(ncs_b);
            8:  return 12'(sclk_b);
            9:  return 12'(busy_b);
            10: return 12'(done_b);
            11: return data1_b;
            12: return data2_b;
            default: return '0;
        endcase
    endfunction

    // Monitor: the only process that steps the counters.
    int   vectors = 0, miscompares = 0;
    int   tog_a = 0, tog_b = 0;
    logic psclk_a = 1'b1, psclk_b = 1'b1, pncs_a = 1'b1, pncs_b = 1'b1;
    exp_t e;

    always @(negedge clk_in) begin
        for (int i = pq.size() - 1; i >= 0; i--) begin
            if (pq[i].at <= cyc) begin
                vectors++;
                if (pq[i].at < cyc || sig(pq[i].sel) !== pq[i].val) begin
                    miscompares++;
                    $display("FAIL %s: got %h expected %h (cycle %0d, due %0d)",
                             pq[i].name, sig(pq[i].sel), pq[i].val, cyc, pq[i].at);
                end
                pq.delete(i);
            end
        end

        if (pncs_a && !ncs_a) tog_a = 0;
        if (pncs_b && !ncs_b) tog_b = 0;
        if (sclk_a !== psclk_a) tog_a++;
        if (sclk_b !== psclk_b) tog_b++;
        psclk_a = sclk_a; psclk_b = sclk_b; pncs_a = ncs_a; pncs_b = ncs_b;

        if (armed && ((ncs_a && !sclk_a) || (ncs_b && !sclk_b))) begin
            miscompares++;
            $display("FAIL sclk_low_while_deselected: got sclk low expected high (cycle %0d)", cyc);
        end

        if (done_a) begin
            vectors++;
            if (q_a.size() == 0) begin
                miscompares++;
                $display("FAIL done_a_unexpected: got done=1 expected 0 (cycle %0d)", cyc);
            end else begin
                e = q_a.pop_front();
                if (data1_a !== e.d1 || data2_a !== e.d2 || err_a !== e.err || cyc != e.at || tog_a != 32) begin
                    miscompares++;
                    $display("FAIL frame_a: got d1=%h d2=%h err=%b cyc=%0d tog=%0d expected d1=%h d2=%h err=%b cyc=%0d tog=32",
                             data1_a, data2_a, err_a, cyc, tog_a, e.d1, e.d2, e.err, e.at);
                end
            end
        end
        if (q_a.size() > 0 && q_a[0].at < cyc) begin
            vectors++;
            miscompares++;
            $display("FAIL done_a_timeout: got no done expected done at cycle %0d", q_a[0].at);
            void'(q_a.pop_front());
        end

        if (done_b) begin
            vectors++;
            if (q_b.size() == 0) begin
                miscompares++;
                $display("FAIL done_b_unexpected: got done=1 expected 0 (cycle %0d)", cyc);
            end else begin
                e = q_b.pop_front();
                if (data1_b !== e.d1 || data2_b !== e.d2 || err_b !== e.err || cyc != e.at || tog_b != 32) begin
                    miscompares++;
                    $display("FAIL frame_b: got d1=%h d2=%h err=%b cyc=%0d tog=%0d expected d1=%h d2=%h err=%b cyc=%0d tog=32",
                             data1_b, data2_b, err_b, cyc, tog_b, e.d1, e.d2, e.err, e.at);
                end
            end
        end
        if (q_b.size() > 0 && q_b[0].at < cyc) begin
            vectors++;
            miscompares++;
            $display("FAIL done_b_timeout: got no done expected done at cycle %0d", q_b[0].at);
            void'(q_b.pop_front());
        end
    end

    task automatic next_cycle();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) next_cycle();
    endtask

    task automatic probe(input int at, input int sel, input logic [11:0] val, input string name);
        pq.push_back('{at: at, sel: sel, val: val, name: name});
    endtask

    task automatic frame_a(input logic [15:0] a, input logic [15:0] b, input logic err);
        int n;
        n = cyc;
        w1_a = a;
        w2_a = b;
        start_a = 1'b1;
        q_a.push_back('{d1: a[11:0], d2: b[11:0], err: err, at: n + 97});
        probe(n + 98, 3, 12'h000, "done_a_one_cycle");
        next_cycle();
        start_a = 1'b0;
        wait_until(n + 110);
    endtask

    int n;

    initial begin
        rst = 1'b1;
        repeat (3) next_cycle();
        rst = 1'b0;
        armed = 1'b1;
        probe(cyc, 0, 12'h001, "rst_ncs_a");
        probe(cyc, 1, 12'h001, "rst_sclk_a");
        probe(cyc, 2, 12'h000, "rst_busy_a");
        probe(cyc, 3, 12'h000, "rst_done_a");
        probe(cyc, 4, 12'h000, "rst_data1_a");
        probe(cyc, 5, 12'h000, "rst_data2_a");
        probe(cyc, 6, 12'h000, "rst_err_a");
        probe(cyc, 7, 12'h001, "rst_ncs_b");
        probe(cyc, 8, 12'h001, "rst_sclk_b");
        next_cycle();

        // Basic frame with timing of the first frame edges.
        n = cyc;
        probe(n, 0, 12'h001, "idle_ncs_a");
        probe(n + 1, 0, 12'h000, "start_ncs_a");
        probe(n + 1, 2, 12'h001, "start_busy_a");
        probe(n + 3, 1, 12'h001, "pre_toggle_sclk_a");
        probe(n + 4, 1, 12'h000, "first_toggle_sclk_a");
        probe(n + 105, 4, 12'hA5C, "hold_data1_a");
        frame_a(16'h0A5C, 16'h0FFF, 1'b0);

        // Start held high: second frame accepted on QUIET exit only.
        n = cyc;
        w1_a = 16'h0123;
        w2_a = 16'h0456;
        start_a = 1'b1;
        q_a.push_back('{d1: 12'h123, d2: 12'h456, err: 1'b0, at: n + 97});
        q_a.push_back('{d1: 12'h789, d2: 12'hABC, err: 1'b0, at: n + 199});
        probe(n + 101, 2, 12'h001, "quiet_busy_a");
        probe(n + 102, 0, 12'h001, "quiet_end_ncs_a");
        probe(n + 102, 2, 12'h000, "quiet_end_busy_a");
        probe(n + 103, 0, 12'h000, "second_fall_ncs_a");
        wait_until(n + 98);
        w1_a = 16'h0789;
        w2_a = 16'h0ABC;
        wait_until(n + 150);
        start_a = 1'b0;
        wait_until(n + 215);

        // Reset mid-frame: no done for the aborted frame.
        n = cyc;
        w1_a = 16'h0FFF;
        w2_a = 16'h0FFF;
        start_a = 1'b1;
        next_cycle();
        start_a = 1'b0;
        wait_until(n + 40);
        rst = 1'b1;
        probe(n + 40, 1, 12'h000, "midframe_sclk_a");
        probe(n + 41, 0, 12'h001, "abort_ncs_a");
        probe(n + 41, 1, 12'h001, "abort_sclk_a");
        probe(n + 41, 2, 12'h000, "abort_busy_a");
        probe(n + 41, 4, 12'h000, "abort_data1_a");
        probe(n + 41, 5, 12'h000, "abort_data2_a");
        probe(n + 97, 3, 12'h000, "abort_no_done_a");
        next_cycle();
        rst = 1'b0;
        wait_until(n + 140);

        // Reset wins over start in the same cycle.
        n = cyc;
        rst = 1'b1;
        start_a = 1'b1;
        probe(n + 1, 0, 12'h001, "rst_prio_ncs_a");
        probe(n + 1, 2, 12'h000, "rst_prio_busy_a");
        next_cycle();
        rst = 1'b0;
        start_a = 1'b0;
        probe(n + 2, 0, 12'h001, "rst_prio_idle_ncs_a");
        next_cycle();

        // Leading-one frames on each channel.
        frame_a(16'h8123, 16'h0ABC, ZC);
        frame_a(16'h0001, 16'h1000, ZC);
        frame_a(16'h0FFF, 16'h0000, 1'b0);

        // CLK_DIV=1: alternating all-zero / all-ones frames.
        for (int k = 0; k < 4; k++) begin
            n = cyc;
            w1_b = (k % 2 == 0) ? 16'h0000 : 16'h0FFF;
            w2_b = (k % 2 == 0) ? 16'h0FFF : 16'h0000;
            start_b = 1'b1;
            q_b.push_back('{d1: w1_b[11:0], d2: w2_b[11:0], err: 1'b0, at: n + 33});
            probe(n + 1, 8, 12'h001, "div1_sclk_b0");
            probe(n + 2, 8, 12'h000, "div1_sclk_b1");
            probe(n + 3, 8, 12'h001, "div1_sclk_b2");
            probe(n + 34, 10, 12'h000, "done_b_one_cycle");
            next_cycle();
            start_b = 1'b0;
            wait_until(n + 45);
        end

        repeat (5) next_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
